// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file sizing, shadow entry type and opcodes for the 16-bit pipeline
package cpu_pkg;
   localparam int NUM_REGS = 16;
   localparam int REG_W = 4;
   typedef logic [REG_W-1:0] reg_t;
   typedef struct packed {
      logic valid;
      reg_t rd;
   } sb_entry_t;
   // ALU ops read rs1/rs2, immediates read only rs1, LUI/JMP read nothing
   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h5;
   localparam logic [3:0] OP_ST   = 4'h6;
   localparam logic [3:0] OP_BEQ  = 4'h7;
   localparam logic [3:0] OP_LUI  = 4'h8;
   localparam logic [3:0] OP_JMP  = 4'h9;
endpackage

// File: rtl/hazard_shadow_pipe.sv
// hazard_shadow_pipe: shift register of in-flight writes from EX1 to WB with
// flush kill of young entries and pending-write bitmap
module hazard_shadow_pipe
   import cpu_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int FLUSH_POS = 2,
   parameter int WB_BYPASS = 0,
   parameter int R0_ZERO   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  reg_t                load_rd,
   input  logic                kill,
   output sb_entry_t           wb_entry,
   output logic [NUM_REGS-1:0] busy
);
   sb_entry_t [DEPTH-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d[0] = '{valid: load, rd: load_rd};
      for (int k = 1; k < DEPTH; k++) pipe_d[k] = pipe_q[k-1];
      for (int k = 0; k < FLUSH_POS && k < DEPTH; k++) if (kill) pipe_d[k].valid = 1'b0;
   end

   // a write-through regfile makes the WB entry visible to ID already
   always_comb begin
      busy = '0;
      for (int k = 0; k < DEPTH - WB_BYPASS; k++) if (pipe_q[k].valid) busy[pipe_q[k].rd] = 1'b1;
      if (R0_ZERO != 0) busy[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) pipe_q <= '0;
      else pipe_q <= pipe_d;

   assign wb_entry = pipe_q[DEPTH-1];
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW stall, branch flush sequencing, WB consistency check
// and saturating statistics for the forwarding-less in-order pipeline
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int FLUSH_POS = 2,
   parameter int WB_BYPASS = 0,
   parameter int R0_ZERO   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic                id_rs1_used,
   input  logic                id_rs2_used,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                id_reg_write,
   input  logic                branch_taken,
   input  logic                wb_reg_write,
   input  logic [REG_W-1:0]    wb_rd,
   output logic                stall_if,
   output logic                stall_id,
   output logic                bubble_ex,
   output logic                flush_id,
   output logic                flush_ex,
   output logic                flush_mem,
   output logic [NUM_REGS-1:0] sb_busy,
   output logic                sb_err,
   output logic [15:0]         stall_cnt,
   output logic [15:0]         flush_cnt
);
   sb_entry_t   wb_entry;
   logic        hazard, stall, load, mismatch, skip;
   logic        err_q, err_d;
   logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   hazard_shadow_pipe #(
      .DEPTH(DEPTH), .FLUSH_POS(FLUSH_POS), .WB_BYPASS(WB_BYPASS), .R0_ZERO(R0_ZERO)
   ) u_pipe (
      .clk(clk), .rst(rst), .load(load), .load_rd(id_rd), .kill(branch_taken),
      .wb_entry(wb_entry), .busy(sb_busy)
   );

   // a flush discards the ID instruction, so it wins over a stall
   always_comb begin
      hazard   = id_valid & ((id_rs1_used & sb_busy[id_rs1]) | (id_rs2_used & sb_busy[id_rs2]));
      stall    = hazard & !branch_taken;
      load     = id_valid & id_reg_write & !hazard & !branch_taken & (R0_ZERO == 0 || id_rd != '0);
      mismatch = wb_reg_write ? (!wb_entry.valid || wb_entry.rd != wb_rd) : wb_entry.valid;
      skip     = R0_ZERO != 0 && wb_rd == '0;
      err_d       = err_q | (mismatch & !skip);
      stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
      flush_cnt_d = (branch_taken && flush_cnt_q != 16'hFFFF) ? flush_cnt_q + 16'd1 : flush_cnt_q;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end

   assign stall_if  = stall;
   assign stall_id  = stall;
   assign bubble_ex = stall;
   assign flush_id  = branch_taken;
   assign flush_ex  = branch_taken;
   assign flush_mem = branch_taken;
   assign sb_err    = err_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of a WB_BYPASS=0 and a WB_BYPASS=1 instance driven in lockstep
module tb_hazard_scoreboard;
   logic clk = 1'b0, rst = 1'b0;
   logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_write = 0;
   logic branch_taken = 0, wb_reg_write = 0;
   logic [3:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, wb_rd = 0;
   logic stall_if0, stall_id0, bubble_ex0, flush_id0, flush_ex0, flush_mem0, sb_err0;
   logic stall_if1, stall_id1, bubble_ex1, flush_id1, flush_ex1, flush_mem1, sb_err1;
   logic [15:0] sb_busy0, stall_cnt0, flush_cnt0, sb_busy1, stall_cnt1, flush_cnt1;
   int cmp = 0, errs = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.WB_BYPASS(0)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .branch_taken(branch_taken), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .stall_if(stall_if0), .stall_id(stall_id0), .bubble_ex(bubble_ex0),
      .flush_id(flush_id0), .flush_ex(flush_ex0), .flush_mem(flush_mem0), .sb_busy(sb_busy0),
      .sb_err(sb_err0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

   hazard_scoreboard #(.WB_BYPASS(1)) dut1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .branch_taken(branch_taken), .wb_reg_write(wb_reg_write),
      .wb_rd(wb_rd), .stall_if(stall_if1), .stall_id(stall_id1), .bubble_ex(bubble_ex1),
      .flush_id(flush_id1), .flush_ex(flush_ex1), .flush_mem(flush_mem1), .sb_busy(sb_busy1),
      .sb_err(sb_err1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      cmp++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic id_set(input logic v, input logic [3:0] r1, input logic u1, input logic [3:0] r2,
                         input logic u2, input logic [3:0] rd, input logic w);
      id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
      id_rd = rd; id_reg_write = w;
      #1;
   endtask

   task automatic stalls(input string tag, input logic e0, input logic e1);
      chk({tag, "_stall_id0"}, {15'd0, stall_id0}, {15'd0, e0});
      chk({tag, "_stall_if0"}, {15'd0, stall_if0}, {15'd0, e0});
      chk({tag, "_bubble0"}, {15'd0, bubble_ex0}, {15'd0, e0});
      chk({tag, "_stall_id1"}, {15'd0, stall_id1}, {15'd0, e1});
   endtask

   initial begin
      #2;
      chk("rst_busy", sb_busy0, 16'h0000);
      chk("rst_err", {15'd0, sb_err0}, 16'h0);
      chk("rst_scnt", stall_cnt0, 16'h0);
      chk("rst_fcnt", flush_cnt1, 16'h0);
      stalls("rst", 1'b0, 1'b0);
      chk("rst_flush", {13'd0, flush_id0, flush_ex0, flush_mem0}, 16'h0);
      step();
      rst = 1'b1;
      // test 1/2: ADD r1 then reader of r1
      id_set(1, 0, 0, 0, 0, 1, 1);
      stalls("t1_issue", 0, 0);
      step();
      id_set(1, 1, 1, 0, 0, 0, 0);
      stalls("t1_c1", 1, 1);
      chk("t1_busy0", sb_busy0, 16'h0002);
      step(); #1;
      stalls("t1_c2", 1, 1);
      step(); #1;
      stalls("t1_c3", 1, 1);
      chk("t1_busy1_c3", sb_busy1, 16'h0002);
      step();
      wb_reg_write = 1; wb_rd = 1; #1;
      stalls("t1_c4", 1, 0);
      chk("t1_busy0_c4", sb_busy0, 16'h0002);
      chk("t1_busy1_c4", sb_busy1, 16'h0000);
      step();
      wb_reg_write = 0; wb_rd = 0; #1;
      stalls("t1_c5", 0, 0);
      chk("t1_scnt0", stall_cnt0, 16'd4);
      chk("t1_scnt1", stall_cnt1, 16'd3);
      chk("t1_err0", {15'd0, sb_err0}, 16'h0);
      chk("t1_err1", {15'd0, sb_err1}, 16'h0);
      step();
      // test 3: r0 writes untracked, r0 reads never stall
      id_set(1, 0, 0, 0, 0, 0, 1);
      step();
      id_set(1, 0, 1, 0, 1, 0, 0);
      stalls("t3", 0, 0);
      chk("t3_busy", sb_busy0, 16'h0000);
      step();
      // test 4: write r2, branch while r2 is in entry 0 and a reader is in ID
      id_set(1, 0, 0, 0, 0, 2, 1);
      step();
      id_set(1, 2, 1, 0, 0, 0, 0);
      branch_taken = 1; #1;
      chk("t4_flush0", {13'd0, flush_id0, flush_ex0, flush_mem0}, 16'h7);
      chk("t4_flush1", {13'd0, flush_id1, flush_ex1, flush_mem1}, 16'h7);
      stalls("t4_br", 0, 0);
      chk("t4_busy_br", sb_busy0, 16'h0004);
      step();
      branch_taken = 0;
      id_set(0, 0, 0, 0, 0, 0, 0);
      chk("t4_flush_off", {13'd0, flush_id0, flush_ex0, flush_mem0}, 16'h0);
      chk("t4_busy0", sb_busy0, 16'h0000);
      chk("t4_busy1", sb_busy1, 16'h0000);
      chk("t4_fcnt0", flush_cnt0, 16'd1);
      chk("t4_fcnt1", flush_cnt1, 16'd1);
      chk("t4_scnt0", stall_cnt0, 16'd4);
      for (int i = 0; i < 4; i++) step();
      chk("t4_err0", {15'd0, sb_err0}, 16'h0);
      chk("t4_err1", {15'd0, sb_err1}, 16'h0);
      // test 5: async reset in the middle of a stall on r3
      id_set(1, 0, 0, 0, 0, 3, 1);
      step();
      id_set(1, 3, 1, 0, 0, 0, 0);
      stalls("t5_pre", 1, 1);
      step();
      #2;
      rst = 1'b0;
      #1;
      stalls("t5_rst", 0, 0);
      chk("t5_busy", sb_busy0, 16'h0000);
      chk("t5_scnt", stall_cnt0, 16'h0);
      chk("t5_fcnt", flush_cnt0, 16'h0);
      chk("t5_err", {15'd0, sb_err0}, 16'h0);
      rst = 1'b1;
      #1;
      stalls("t5_rel", 0, 0);
      step();
      // test 6: WB write with empty shadow pipeline
      id_set(0, 0, 0, 0, 0, 0, 0);
      wb_reg_write = 1; wb_rd = 5; #1;
      chk("t6_pre", {15'd0, sb_err0}, 16'h0);
      step();
      wb_reg_write = 0; wb_rd = 0; #1;
      chk("t6_set0", {15'd0, sb_err0}, 16'h1);
      chk("t6_set1", {15'd0, sb_err1}, 16'h1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t6_hold", {15'd0, sb_err0}, 16'h1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
